cmm_operand_gather: RTL

CMM_OPERAND_GATHER -- requirements
Module: cmm_operand_gather

---
 rtl/cmm_pkg.sv | 29 ++
 rtl/cmm_operand_bank.sv | 98 +++++++++
 rtl/cmm_operand_gather.sv | 102 ++++++++++
 3 files changed

// File: rtl/cmm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmm_pkg
// Description : Shared sizes, operand-pair layout and bank-state encoding for
//               the complex matrix-multiply operand gather.
// Revision    : 1.0 - initial release
// ============================================================================
package cmm_pkg;

    localparam int CMM_SIZE  = 16;
    localparam int CMM_WIDTH = 64;

    // Field order places x_re in the least-significant word, matching the
    // flattened operand vector layout (4i = x_re ... 4i+3 = y_im).
    typedef struct packed {
        logic [CMM_WIDTH-1:0] y_im;
        logic [CMM_WIDTH-1:0] y_re;
        logic [CMM_WIDTH-1:0] x_im;
        logic [CMM_WIDTH-1:0] x_re;
    } cmm_pair_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } cmm_bank_state_e;

endpackage
`default_nettype wire

// File: rtl/cmm_operand_bank.sv
`default_nettype none
// ============================================================================
// Module      : cmm_operand_bank
// Description : One ping-pong bank of operand pairs with its fill state,
//               stored pair count and zero padding beyond that count.
// Revision    : 1.0 - initial release
// ============================================================================
module cmm_operand_bank
    import cmm_pkg::*;
#(
    parameter  int SIZE    = CMM_SIZE,
    parameter  int WIDTH   = CMM_WIDTH,
    localparam int C_IDX_W = $clog2(SIZE),
    localparam int C_CNT_W = $clog2(SIZE) + 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_wr_en,
    input  logic                      i_wr_close,
    input  logic [C_IDX_W-1:0]        i_wr_idx,
    input  logic [4*WIDTH-1:0]        i_wr_data,
    input  logic                      i_drain,
    input  logic                      i_flush,
    output cmm_bank_state_e           o_state,
    output logic [SIZE*4*WIDTH-1:0]   o_operands
);

    cmm_bank_state_e      r_state;
    cmm_bank_state_e      w_state_nxt;
    logic [C_CNT_W-1:0]   r_count;
    logic [C_CNT_W-1:0]   w_count_nxt;
    logic                 w_full;
    logic [4*WIDTH-1:0]   r_mem [SIZE];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= BANK_EMPTY;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (i_flush) begin
            w_state_nxt = BANK_EMPTY;
            w_count_nxt = '0;
        end else begin
            case (r_state)
                BANK_EMPTY, BANK_FILLING: begin
                    if (i_wr_en) begin
                        if (i_wr_close) begin
                            w_state_nxt = BANK_FULL;
                            w_count_nxt = {1'b0, i_wr_idx} + C_CNT_W'(1);
                        end else begin
                            w_state_nxt = BANK_FILLING;
                        end
                    end
                end
                BANK_FULL: begin
                    if (i_drain) begin
                        w_state_nxt = BANK_EMPTY;
                        w_count_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = BANK_EMPTY;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_state = r_state;
        w_full  = (r_state == BANK_FULL);
    end

    // Payload is never reset; the state/count masking hides stale entries.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_entry
            logic w_keep;
            assign w_keep = w_full && (C_CNT_W'(gi) < r_count);
            assign o_operands[gi*4*WIDTH +: 4*WIDTH] = w_keep ? r_mem[gi] : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/cmm_operand_gather.sv
`default_nettype none
// ============================================================================
// Module      : cmm_operand_gather
// Description : Collects streamed complex operand pairs into ping-pong banks
//               and presents each closed bank as one packed operand vector.
// Revision    : 1.0 - initial release
// ============================================================================
module cmm_operand_gather
    import cmm_pkg::*;
#(
    parameter int SIZE  = CMM_SIZE,
    parameter int WIDTH = CMM_WIDTH
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            elem_valid_i,
    output logic                            elem_ready_o,
    input  logic [WIDTH-1:0]                elem_x_re_i,
    input  logic [WIDTH-1:0]                elem_x_im_i,
    input  logic [WIDTH-1:0]                elem_y_re_i,
    input  logic [WIDTH-1:0]                elem_y_im_i,
    input  logic                            elem_last_i,
    input  logic                            flush_i,
    output logic [SIZE*4-1:0][WIDTH-1:0]    operands_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic                            busy_o
);

    localparam int C_IDX_W = $clog2(SIZE);

    logic [C_IDX_W-1:0]       r_wr_idx;
    logic                     r_wr_bank;
    logic                     r_rd_bank;
    logic                     w_accept;
    logic                     w_close;
    logic                     w_drain;
    logic [4*WIDTH-1:0]       w_wr_data;
    cmm_bank_state_e          w_bank_state [2];
    logic [SIZE*4*WIDTH-1:0]  w_bank_ops   [2];

    assign w_wr_data    = {elem_y_im_i, elem_y_re_i, elem_x_im_i, elem_x_re_i};
    assign elem_ready_o = !flush_i && (w_bank_state[r_wr_bank] != BANK_FULL);
    assign w_accept     = elem_valid_i && elem_ready_o;
    assign w_close      = w_accept && ((r_wr_idx == C_IDX_W'(SIZE - 1)) || elem_last_i);
    assign out_valid_o  = (w_bank_state[r_rd_bank] == BANK_FULL);
    assign w_drain      = out_valid_o && out_ready_i && !flush_i;
    assign busy_o       = (w_bank_state[0] != BANK_EMPTY) || (w_bank_state[1] != BANK_EMPTY);
    // A bank that is not FULL already drives zeros, so no extra gating here.
    assign operands_o   = w_bank_ops[r_rd_bank];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else if (flush_i) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_close) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + C_IDX_W'(1);
                end
            end
            if (w_drain) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    generate
        for (genvar gb = 0; gb < 2; gb++) begin : g_bank
            logic w_sel_wr;
            logic w_sel_rd;
            assign w_sel_wr = (r_wr_bank == 1'(gb));
            assign w_sel_rd = (r_rd_bank == 1'(gb));

            cmm_operand_bank #(
                .SIZE  (SIZE),
                .WIDTH (WIDTH)
            ) u_bank (
                .i_clk      (clk_i),
                .i_rst_n    (rst_ni),
                .i_wr_en    (w_accept && w_sel_wr),
                .i_wr_close (w_close),
                .i_wr_idx   (r_wr_idx),
                .i_wr_data  (w_wr_data),
                .i_drain    (w_drain && w_sel_rd),
                .i_flush    (flush_i),
                .o_state    (w_bank_state[gb]),
                .o_operands (w_bank_ops[gb])
            );
        end
    endgenerate

endmodule
`default_nettype wire
